multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle sequencer for the 3-bit-opcode core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB using a ready handshake with instruction and data memory. It produces the per-cycle datapath strobes (PC/IR load, register write, memory write, result mux select). It also provides a memory-timeout error and a retired-instruction counter. It sits between the memories and the register file/ALU datapath.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for MemReady; 0 disables timeout
CNT_W, 16, width of RetireCount

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
OpCode  input  3  opcode field from instruction register, valid in DECODE
InstrReady  input  1  instruction memory has data for the current InstrReq
MemReady  input  1  data memory completed the current MemReq
InstrReq  output  1  request instruction fetch
InstrRegEnable  output  1  load instruction register
PCWriteEnable  output  1  advance PC
MemReq  output  1  data memory access request
MemWriteEnable  output  1  data memory write (store)
RegWriteEnable  output  1  register file write
ResultSrc  output  1  0 = data memory, 1 = ALU
MemError  output  1  one-cycle pulse on memory timeout
State  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
RetireCount  output  CNT_W  number of retired instructions, wraps

Behaviour:
- Opcode classes: 3'b000 LOAD; 3'b100 STORE; all others ALU.
- Reset (rst high at clock edge):
  - State=FETCH, latched opcode=3'b001, timeout counter=0, RetireCount=0.
  - While rst is high, all strobe outputs are forced 0 and ResultSrc=1.
  - Reset mid-MEM or mid-WB aborts the instruction; no write strobe is asserted in the reset cycle.
- Outputs are combinational from state and the latched opcode. InstrRegEnable and PCWriteEnable are Mealy outputs (FETCH && InstrReady).
- FETCH:
  - InstrReq=1.
  - Stays in FETCH until InstrReady=1.
  - In that cycle InstrRegEnable=1 and PCWriteEnable=1 for exactly one cycle; next state is DECODE.
- DECODE: latch OpCode; 1 cycle; next state EXEC.
- EXEC: 1 cycle. LOAD or STORE -> MEM; ALU -> WB.
- MEM:
  - MemReq=1 every cycle in MEM. MemWriteEnable=1 every cycle in MEM when latched op is STORE, else 0.
  - Timeout counter starts at 0 on entry and increments each MEM cycle without MemReady.
  - MemReady=1: LOAD -> WB; STORE -> FETCH, and the store retires.
  - With MEM_TIMEOUT>0, if the counter equals MEM_TIMEOUT-1 and MemReady=0: MemError=1 for that cycle, next state FETCH, no retire, no register write.
  - MemReady in the same cycle as timeout: ready wins, no error.
- WB:
  - RegWriteEnable=1 for exactly one cycle.
  - ResultSrc=0 if latched op is LOAD, else 1.
  - Next state FETCH; the instruction retires.
- ResultSrc=1 in every state except WB-with-LOAD.
- RetireCount increments by 1 on the retiring edge and wraps from 2^CNT_W-1 to 0.
- InstrReady outside FETCH and MemReady outside MEM are ignored.
- Latency:
  - ALU op with zero-wait fetch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 + memory wait cycles.
  - STORE: 4 + memory wait cycles.
- No state is ever held with RegWriteEnable and MemWriteEnable both 1.

Test Plan:
- ALU op 3'b010, InstrReady=1 immediately -> State sequence 0,1,2,4,0; RegWriteEnable=1 only in the WB cycle with ResultSrc=1; RetireCount 0->1.
- LOAD 3'b000, MemReady asserted on the 3rd MEM cycle -> MemReq=1 for 3 cycles, MemWriteEnable=0, then WB with RegWriteEnable=1 and ResultSrc=0.
- STORE 3'b100, MemReady on the 1st MEM cycle -> MemWriteEnable=1 for 1 cycle, RegWriteEnable never 1, next State=FETCH, RetireCount increments.
- MEM_TIMEOUT=4, LOAD with MemReady held 0 -> 4 MEM cycles, MemError pulse in the 4th, State=FETCH, no RegWriteEnable, RetireCount unchanged; repeat with MemReady=1 in the 4th cycle -> no MemError, goes to WB.
- rst asserted during the 2nd MEM cycle of a STORE -> next cycle State=FETCH, RetireCount=0, MemWriteEnable=0 during reset.
- CNT_W=2, retire 5 ALU ops -> RetireCount sequence 1,2,3,0,1; FETCH held 3 cycles with InstrReady=0 -> InstrReq=1 throughout, PCWriteEnable pulses once only.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake/strobe bundle between the multi-cycle sequencer and its memories/datapath.
// The master modport is the controller side; the slave modport is the memory/datapath side.
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic [2:0]       OpCode;
    logic             InstrReady;
    logic             MemReady;
    logic             InstrReq;
    logic             InstrRegEnable;
    logic             PCWriteEnable;
    logic             MemReq;
    logic             MemWriteEnable;
    logic             RegWriteEnable;
    logic             ResultSrc;
    logic             MemError;
    logic [2:0]       State;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        input  OpCode,
        input  InstrReady,
        input  MemReady,
        output InstrReq,
        output InstrRegEnable,
        output PCWriteEnable,
        output MemReq,
        output MemWriteEnable,
        output RegWriteEnable,
        output ResultSrc,
        output MemError,
        output State,
        output RetireCount
    );

    modport slave (
        output OpCode,
        output InstrReady,
        output MemReady,
        input  InstrReq,
        input  InstrRegEnable,
        input  PCWriteEnable,
        input  MemReq,
        input  MemWriteEnable,
        input  RegWriteEnable,
        input  ResultSrc,
        input  MemError,
        input  State,
        input  RetireCount
    );

endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 3-bit-opcode core, with
// memory-timeout error reporting and a wrapping retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_RESET = 3'b001;

    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [2:0]       op;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] retire_count;

    logic is_load;
    logic is_store;
    logic timeout;

    always_comb begin
        is_load  = (op == OP_LOAD);
        is_store = (op == OP_STORE);
        // Ready in the final allowed cycle takes precedence over the timeout.
        timeout  = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST) && !bus.MemReady;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            op           <= OP_RESET;
            to_cnt       <= '0;
            retire_count <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.InstrReady) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    op    <= bus.OpCode;
                    state <= EXEC;
                end
                EXEC: begin
                    to_cnt <= '0;
                    state  <= (is_load || is_store) ? MEM : WB;
                end
                MEM: begin
                    if (bus.MemReady) begin
                        if (is_store) begin
                            state        <= FETCH;
                            retire_count <= retire_count + CNT_W'(1);
                        end else begin
                            state <= WB;
                        end
                    end else if (timeout) begin
                        state <= FETCH;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WB: begin
                    state        <= FETCH;
                    retire_count <= retire_count + CNT_W'(1);
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Strobes are decoded from state and latched opcode; reset masks them all.
    always_comb begin
        bus.InstrReq       = 1'b0;
        bus.InstrRegEnable = 1'b0;
        bus.PCWriteEnable  = 1'b0;
        bus.MemReq         = 1'b0;
        bus.MemWriteEnable = 1'b0;
        bus.RegWriteEnable = 1'b0;
        bus.ResultSrc      = 1'b1;
        bus.MemError       = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.InstrReq       = 1'b1;
                    bus.InstrRegEnable = bus.InstrReady;
                    bus.PCWriteEnable  = bus.InstrReady;
                end
                MEM: begin
                    bus.MemReq         = 1'b1;
                    bus.MemWriteEnable = is_store;
                    bus.MemError       = timeout;
                end
                WB: begin
                    bus.RegWriteEnable = 1'b1;
                    bus.ResultSrc      = !is_load;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.State       = state;
    assign bus.RetireCount = retire_count;

    a_no_dual_write: assert property (@(posedge clk)
        !(bus.RegWriteEnable && bus.MemWriteEnable));

    a_error_only_in_mem: assert property (@(posedge clk)
        bus.MemError |-> (state == MEM));

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each driven cycle pushes its expected output vector, and a
// negedge monitor pops and compares it against the controller outputs.
module tb_multicycle_controller;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 2;

    logic clk;
    logic rst;

    multicycle_controller_if #(.CNT_W(CW)) bus ();

    multicycle_controller #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [CW-1:0] exp_retire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {State, InstrReq, InstrRegEnable, PCWriteEnable, MemReq, MemWriteEnable,
    //  RegWriteEnable, ResultSrc, MemError, RetireCount}
    function automatic logic [12:0] mk(input logic [2:0] st, input bit ireq, input bit ire,
                                       input bit pcwe, input bit mreq, input bit mwe,
                                       input bit rwe, input bit rsrc, input bit merr);
        return {st, ireq, ire, pcwe, mreq, mwe, rwe, rsrc, merr, exp_retire};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'({bus.State, bus.InstrReq, bus.InstrRegEnable, bus.PCWriteEnable,
                          bus.MemReq, bus.MemWriteEnable, bus.RegWriteEnable, bus.ResultSrc,
                          bus.MemError, bus.RetireCount}), 32'(e));
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] ro();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic step(input logic r, input logic [2:0] oc, input logic ir, input logic mr,
                        input string tag, input logic [12:0] e, input bit push);
        rst            = r;
        bus.OpCode     = oc;
        bus.InstrReady = ir;
        bus.MemReady   = mr;
        if (push) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    // mw: MEM cycles without MemReady before it arrives; rst_at: MEM cycle index to reset in.
    task automatic run_instr(input logic [2:0] op, input int fw, input int mw, input int rst_at);
        bit is_ld;
        bit is_st;
        bit ready;
        bit to;
        is_ld = (op == 3'b000);
        is_st = (op == 3'b100);
        for (int i = 0; i < fw; i++)
            step(1'b0, ro(), 1'b0, rb(), "fetch_wait", mk(3'd0, 1, 0, 0, 0, 0, 0, 1, 0), 1);
        step(1'b0, ro(), 1'b1, rb(), "fetch", mk(3'd0, 1, 1, 1, 0, 0, 0, 1, 0), 1);
        step(1'b0, op, rb(), rb(), "decode", mk(3'd1, 0, 0, 0, 0, 0, 0, 1, 0), 1);
        step(1'b0, ro(), rb(), rb(), "exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0), 1);
        if (is_ld || is_st) begin
            for (int i = 0; i < 64; i++) begin
                if (i == rst_at) begin
                    step(1'b1, ro(), 1'b1, 1'b1, "mem_rst", mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 0), 1);
                    exp_retire = '0;
                    return;
                end
                ready = (i == mw);
                to    = !ready && (i == int'(TO) - 1);
                step(1'b0, ro(), rb(), ready, to ? "mem_timeout" : "mem",
                     mk(3'd3, 0, 0, 0, 1, is_st, 0, 1, to), 1);
                if (to) return;
                if (ready) begin
                    if (is_st) begin
                        exp_retire = exp_retire + 1'b1;
                        return;
                    end
                    break;
                end
            end
        end
        step(1'b0, ro(), rb(), rb(), "wb", mk(3'd4, 0, 0, 0, 0, 0, 1, !is_ld, 0), 1);
        exp_retire = exp_retire + 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_retire = '0;
        step(1'b1, 3'd0, 1'b0, 1'b0, "reset0", '0, 0);
        step(1'b1, 3'd0, 1'b1, 1'b1, "reset", mk(3'd0, 0, 0, 0, 0, 0, 0, 1, 0), 1);

        run_instr(3'b010, 0, 0, -1);      // ALU, zero-wait fetch
        run_instr(3'b000, 0, 2, -1);      // LOAD, ready on 3rd MEM cycle
        run_instr(3'b100, 0, 0, -1);      // STORE, ready on 1st MEM cycle
        run_instr(3'b000, 1, 99, -1);     // LOAD timeout
        run_instr(3'b000, 0, 3, -1);      // LOAD, ready coincides with timeout
        run_instr(3'b100, 0, 99, -1);     // STORE timeout
        run_instr(3'b110, 0, 0, -1);      // ALU to get a nonzero count before reset
        run_instr(3'b100, 0, 99, 1);      // STORE, reset in 2nd MEM cycle

        // Five ALU ops: count wraps 1,2,3,0,1; one with a 3-cycle fetch stall.
        run_instr(3'b010, 0, 0, -1);
        run_instr(3'b111, 3, 0, -1);
        run_instr(3'b001, 0, 0, -1);
        run_instr(3'b011, 0, 0, -1);
        run_instr(3'b101, 0, 0, -1);

        for (int k = 0; k < 10; k++)
            run_instr(ro(), $urandom_range(0, 2), $urandom_range(0, 5), -1);

        step(1'b0, ro(), 1'b0, rb(), "idle", mk(3'd0, 1, 0, 0, 0, 0, 0, 1, 0), 1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
